// File: rtl/rc_pkg.sv
// rc_pkg: state encoding and failure codes shared by the retire checker.
package rc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } rc_state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_MISMATCH = 3'd1;
    localparam logic [2:0] FC_SKIP     = 3'd2;
    localparam logic [2:0] FC_HALT     = 3'd3;
    localparam logic [2:0] FC_TIMEOUT  = 3'd4;

endpackage

// File: rtl/rc_table.sv
// rc_table: checkpoint table, one {num_inst, answer} word per entry.
module rc_table #(
    parameter int NUM_TEST = 17,
    parameter int IDX_W    = 5
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_num,
    input  logic [31:0]      wr_ans,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_num,
    output logic [31:0]      rd_ans
);

    localparam logic [IDX_W:0] NT = (IDX_W+1)'(NUM_TEST);

    logic [63:0] mem [NUM_TEST];

    always_ff @(posedge CLK)
        if (we && {1'b0, wr_idx} < NT)
            mem[wr_idx] <= {wr_num, wr_ans};

    // Reads past the table only happen once every checkpoint is consumed.
    assign {rd_num, rd_ans} = ({1'b0, rd_idx} < NT) ? mem[rd_idx] : 64'd0;

endmodule

// File: rtl/retire_checker.sv
// retire_checker: compares core retirement against a checkpoint table and reports a verdict.
// Optional watchdog enabled by defining RC_TIMEOUT_EN.
module retire_checker
    import rc_pkg::*;
#(
    parameter int NUM_TEST = 17,
    parameter int IDX_W    = 5,
    parameter int TIMEOUT  = 1000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CFG_WE,
    input  logic [IDX_W-1:0] CFG_IDX,
    input  logic [31:0]      CFG_NUM_INST,
    input  logic [31:0]      CFG_ANS,
    input  logic [IDX_W:0]   CFG_COUNT,
    input  logic             START,
    input  logic [31:0]      NUM_INST,
    input  logic [31:0]      OUTPUT_PORT,
    input  logic             HALT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [2:0]       FAIL_CODE,
    output logic [IDX_W-1:0] FAIL_IDX,
    output logic [31:0]      FAIL_VALUE,
    output logic [31:0]      CYCLE
);

    localparam logic [IDX_W:0] NT = (IDX_W+1)'(NUM_TEST);

    rc_state_t        state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, ptr_adv, count, count_n, cnt_sat;
    logic [31:0]      cycle_n, cycle_inc, exp_num, exp_ans, fail_value_n;
    logic [2:0]       fail_code_n;
    logic [IDX_W-1:0] fail_idx_n;
    logic             pending, hit, f_mis, f_skip, timeout;

    // A write coinciding with START is dropped so the run sees the old entry.
    rc_table #(.NUM_TEST(NUM_TEST), .IDX_W(IDX_W)) u_table (
        .CLK    (CLK),
        .we     (CFG_WE && state != ST_RUN && !START),
        .wr_idx (CFG_IDX),
        .wr_num (CFG_NUM_INST),
        .wr_ans (CFG_ANS),
        .rd_idx (ptr),
        .rd_num (exp_num),
        .rd_ans (exp_ans)
    );

    assign cnt_sat = (CFG_COUNT > NT) ? NT[IDX_W-1:0] : CFG_COUNT[IDX_W-1:0];

    always_comb begin
        pending      = ptr < count;
        hit          = pending && NUM_INST == exp_num;
        f_mis        = hit && OUTPUT_PORT != exp_ans;
        f_skip       = pending && NUM_INST > exp_num;
        ptr_adv      = ptr + IDX_W'(hit && !f_mis);
        cycle_inc    = (CYCLE == 32'hFFFF_FFFF) ? CYCLE : CYCLE + 32'd1;
`ifdef RC_TIMEOUT_EN
        timeout      = cycle_inc == 32'(TIMEOUT);
`else
        timeout      = 1'b0;
`endif
        state_n      = state;
        ptr_n        = ptr;
        count_n      = count;
        cycle_n      = CYCLE;
        fail_code_n  = FAIL_CODE;
        fail_idx_n   = FAIL_IDX;
        fail_value_n = FAIL_VALUE;
        if (state == ST_RUN) begin
            cycle_n = cycle_inc;
            ptr_n   = ptr_adv;
            if (f_mis || f_skip) begin
                state_n      = ST_FAIL;
                fail_code_n  = f_mis ? FC_MISMATCH : FC_SKIP;
                fail_idx_n   = ptr;
                fail_value_n = OUTPUT_PORT;
            end else if (HALT) begin
                state_n      = (ptr_adv == count) ? ST_PASS : ST_FAIL;
                fail_code_n  = (ptr_adv == count) ? FC_NONE : FC_HALT;
                fail_idx_n   = (ptr_adv == count) ? FAIL_IDX : ptr_adv;
                fail_value_n = (ptr_adv == count) ? FAIL_VALUE : OUTPUT_PORT;
            end else if (timeout) begin
                state_n      = ST_FAIL;
                fail_code_n  = FC_TIMEOUT;
                fail_idx_n   = ptr;
                fail_value_n = OUTPUT_PORT;
            end
        end else if (START) begin
            state_n      = ST_RUN;
            count_n      = cnt_sat;
            ptr_n        = '0;
            cycle_n      = '0;
            fail_code_n  = FC_NONE;
            fail_idx_n   = '0;
            fail_value_n = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            count      <= '0;
            CYCLE      <= '0;
            FAIL_CODE  <= FC_NONE;
            FAIL_IDX   <= '0;
            FAIL_VALUE <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            count      <= count_n;
            CYCLE      <= cycle_n;
            FAIL_CODE  <= fail_code_n;
            FAIL_IDX   <= fail_idx_n;
            FAIL_VALUE <= fail_value_n;
        end
    end

    assign BUSY = state == ST_RUN;
    assign DONE = state == ST_PASS || state == ST_FAIL;
    assign PASS = state == ST_PASS;

endmodule

// File: tb/tb_retire_checker.sv
// tb_retire_checker: directed and randomized runs against a behavioural checkpoint model.
module tb_retire_checker;

    localparam int NT = 17;
    localparam int IW = 5;
    localparam int TO = 20;
`ifdef RC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLK = 1'b0, RST = 1'b1;
    logic          CFG_WE = 1'b0, START = 1'b0, HALT = 1'b0;
    logic [IW-1:0] CFG_IDX = '0;
    logic [31:0]   CFG_NUM_INST = '0, CFG_ANS = '0, NUM_INST = '0, OUTPUT_PORT = '0;
    logic [IW:0]   CFG_COUNT = '0;
    logic          BUSY, DONE, PASS;
    logic [2:0]    FAIL_CODE;
    logic [IW-1:0] FAIL_IDX;
    logic [31:0]   FAIL_VALUE, CYCLE;

    retire_checker #(.NUM_TEST(NT), .IDX_W(IW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
        .CFG_NUM_INST(CFG_NUM_INST), .CFG_ANS(CFG_ANS), .CFG_COUNT(CFG_COUNT),
        .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .FAIL_CODE(FAIL_CODE),
        .FAIL_IDX(FAIL_IDX), .FAIL_VALUE(FAIL_VALUE), .CYCLE(CYCLE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0, n_errors = 0;

    // Model: 0 idle, 1 run, 2 pass, 3 fail
    int          m_st = 0, m_ptr = 0, m_cnt = 0, m_fc = 0, m_fi = 0;
    longint      m_cyc = 0;
    logic [31:0] m_fv = '0;
    logic [31:0] t_num [NT];
    logic [31:0] t_ans [NT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_fail(input int code, input int idx);
        m_st = 3;
        m_fc = code;
        m_fi = idx;
        m_fv = OUTPUT_PORT;
    endtask

    task automatic model_update();
        int p;
        if (RST) begin
            m_st = 0; m_ptr = 0; m_cnt = 0; m_cyc = 0; m_fc = 0; m_fi = 0; m_fv = '0;
        end else if (m_st == 1) begin
            p = m_ptr;
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
            if (p < m_cnt && NUM_INST >= t_num[p]) begin
                if (NUM_INST != t_num[p]) model_fail(2, p);
                else if (OUTPUT_PORT != t_ans[p]) model_fail(1, p);
                else m_ptr++;
            end
            if (m_st == 1 && HALT) begin
                if (m_ptr == m_cnt) m_st = 2;
                else model_fail(3, m_ptr);
            end else if (m_st == 1 && TO_EN && m_cyc == TO) model_fail(4, p);
        end else begin
            if (CFG_WE && !START && int'(CFG_IDX) < NT) begin
                t_num[CFG_IDX] = CFG_NUM_INST;
                t_ans[CFG_IDX] = CFG_ANS;
            end
            if (START) begin
                m_st = 1; m_ptr = 0; m_cyc = 0; m_fc = 0; m_fi = 0; m_fv = '0;
                m_cnt = (int'(CFG_COUNT) > NT) ? NT : int'(CFG_COUNT);
            end
        end
    endtask

    task automatic compare_all();
        check("busy", BUSY, m_st == 1);
        check("done", DONE, m_st >= 2);
        check("pass", PASS, m_st == 2);
        check("fail_code", FAIL_CODE, m_fc);
        check("fail_idx", FAIL_IDX, m_fi);
        check("fail_value", FAIL_VALUE, m_fv);
        check("cycle", CYCLE, m_cyc[31:0]);
    endtask

    task automatic step();
        model_update();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic write(input int idx, input logic [31:0] num, input logic [31:0] ans);
        CFG_WE = 1'b1; CFG_IDX = IW'(idx); CFG_NUM_INST = num; CFG_ANS = ans;
        step();
        CFG_WE = 1'b0;
    endtask

    task automatic start(input int cnt);
        CFG_COUNT = (IW+1)'(cnt); START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic drive(input logic [31:0] num, input logic [31:0] out, input logic halt);
        NUM_INST = num; OUTPUT_PORT = out; HALT = halt;
        step();
        HALT = 1'b0;
    endtask

    task automatic load_plan_table();
        write(0, 32'd4, 32'h0eec);
        write(1, 32'd6, 32'h0000);
        write(2, 32'd8, 32'h0001);
    endtask

    initial begin
        logic [31:0] num, base;
        step();
        step();
        RST = 1'b0;
        check("reset_cycle", CYCLE, 32'd0);
        check("reset_busy", BUSY, 1'b0);

        // Nominal pass through three checkpoints
        load_plan_table();
        start(3);
        for (int n = 0; n <= 10; n++)
            drive(n, (n == 4) ? 32'h0eec : (n == 8) ? 32'h1 : (n == 6) ? 32'h0 : 32'h55, n == 10);
        check("tp_pass", PASS, 1'b1);
        check("tp_pass_done", DONE, 1'b1);
        check("tp_pass_code", FAIL_CODE, 32'd0);

        // Value mismatch on first checkpoint
        start(3);
        drive(4, 32'h0eed, 1'b0);
        check("tp_mis_code", FAIL_CODE, 32'd1);
        check("tp_mis_idx", FAIL_IDX, 32'd0);
        check("tp_mis_val", FAIL_VALUE, 32'h0eed);

        // Skipped checkpoint
        start(3);
        drive(4, 32'h0eec, 1'b0);
        drive(7, 32'h0, 1'b0);
        check("tp_skip_code", FAIL_CODE, 32'd2);
        check("tp_skip_idx", FAIL_IDX, 32'd1);

        // Halt with a checkpoint still pending, then restart
        start(3);
        drive(4, 32'h0eec, 1'b0);
        drive(6, 32'h0, 1'b0);
        drive(6, 32'h0, 1'b1);
        check("tp_halt_code", FAIL_CODE, 32'd3);
        check("tp_halt_idx", FAIL_IDX, 32'd2);
        start(3);
        check("tp_restart_busy", BUSY, 1'b1);
        check("tp_restart_cycle", CYCLE, 32'd0);
        check("tp_restart_code", FAIL_CODE, 32'd0);
        RST = 1'b1; step(); RST = 1'b0;

        // Empty table passes on first HALT; reset mid-run
        start(0);
        for (int c = 1; c <= 5; c++) drive(32'd100, 32'd0, c == 5);
        check("tp_cnt0_pass", PASS, 1'b1);
        check("tp_cnt0_cycle", CYCLE, 32'd5);
        start(0);
        for (int c = 0; c < 3; c++) drive(32'd100, 32'd0, 1'b0);
        RST = 1'b1; step(); RST = 1'b0;
        check("tp_rst_busy", BUSY, 1'b0);
        check("tp_rst_cycle", CYCLE, 32'd0);

        // Watchdog
        start(0);
        for (int c = 0; c < 25; c++) drive(32'd0, 32'd0, 1'b0);
        if (TO_EN) begin
            check("tp_to_code", FAIL_CODE, 32'd4);
            check("tp_to_cycle", CYCLE, 32'd20);
        end else begin
            check("tp_noto_busy", BUSY, 1'b1);
            check("tp_noto_cycle", CYCLE, 32'd25);
        end
        RST = 1'b1; step(); RST = 1'b0;

        // Randomized runs against the model
        for (int r = 0; r < 40; r++) begin
            base = $urandom_range(0, 5);
            for (int i = 0; i < NT; i++) begin
                base = base + $urandom_range(1, 3);
                write(i, base, $urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) write($urandom_range(NT, 31), 32'd0, 32'd0);
            start($urandom_range(0, 31));
            num = 0;
            for (int c = 0; c < 100 && m_st == 1; c++) begin
                num = num + (($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1));
                NUM_INST = num;
                OUTPUT_PORT = (m_ptr < m_cnt && num == t_num[m_ptr] && $urandom_range(0, 11) != 0)
                              ? t_ans[m_ptr] : 32'($urandom_range(0, 7));
                HALT = ($urandom_range(0, 29) == 0) ||
                       (m_ptr >= m_cnt && $urandom_range(0, 3) == 0);
                CFG_WE = $urandom_range(0, 7) == 0;
                START = $urandom_range(0, 7) == 0;
                CFG_IDX = IW'($urandom_range(0, NT - 1));
                CFG_NUM_INST = $urandom;
                RST = $urandom_range(0, 199) == 0;
                step();
                CFG_WE = 1'b0; START = 1'b0; HALT = 1'b0; RST = 1'b0;
            end
            step();
            if (m_st == 1) begin
                RST = 1'b1; step(); RST = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/retire_checker.md
# retire_checker

Synthesizable self-check block sitting directly downstream of the RISC-V core top. Each cycle it samples the core's retired-instruction count, output port and halt flag. It compares them against a preloaded table of expected checkpoints and reports a registered pass/fail verdict, failing index and cycle count. This lets FPGA or emulation runs self-check without a simulation testbench.

## Interface
Parameters:
- NUM_TEST, 17: table depth (checkpoints).
- IDX_W, 5: index width; must satisfy 2^IDX_W > NUM_TEST.
- TIMEOUT, 1000000: watchdog limit in cycles (used only with RC_TIMEOUT_EN).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  one clock; reset is synchronous and active-high.
- CFG_WE  in  1  table write strobe; honoured only outside RUN.
- CFG_IDX  in  IDX_W  table entry index; writes with CFG_IDX >= NUM_TEST are ignored.
- CFG_NUM_INST  in  32  expected NUM_INST value for the entry.
- CFG_ANS  in  32  expected OUTPUT_PORT value for the entry.
- CFG_COUNT  in  IDX_W+1  number of valid entries; sampled on START.
- START  in  1  begin a run; honoured only outside RUN.
- NUM_INST  in  32  core retired-instruction count.
- OUTPUT_PORT  in  32  core output port.
- HALT  in  1  core halt flag.
- BUSY  out  1  high in RUN.
- DONE  out  1  high in PASS or FAIL.
- PASS  out  1  high in PASS.
- FAIL_CODE  out  3  0 none, 1 value mismatch, 2 checkpoint skipped, 3 halt with checkpoints pending, 4 timeout.
- FAIL_IDX  out  IDX_W  table index at failure.
- FAIL_VALUE  out  32  OUTPUT_PORT sampled at failure.
- CYCLE  out  32  cycles spent in RUN.

## Operation
- States: IDLE, RUN, PASS, FAIL.
- Table contents are not reset. All other state is reset.
- Entries 0..count-1 must be strictly ascending in NUM_INST. Benches load only such tables.
- IDLE/PASS/FAIL: CFG_WE writes the entry. START latches count := CFG_COUNT (saturated to NUM_TEST), sets ptr := 0, clears CYCLE, FAIL_CODE, FAIL_IDX and FAIL_VALUE, and goes to RUN.
- RUN, every cycle:
  - CYCLE increments, saturating at 0xFFFFFFFF.
  - Checkpoint pending (ptr < count), evaluated in this order:
    - NUM_INST == exp_num[ptr] and OUTPUT_PORT == exp_ans[ptr]: ptr++.
    - NUM_INST == exp_num[ptr] and values differ: FAIL with code 1.
    - NUM_INST > exp_num[ptr]: FAIL with code 2.
  - HALT: if no failure this cycle and ptr (after increment) == count, go to PASS; otherwise FAIL with code 3 (unless code 1 or 2 already applies).
- Priority in one cycle: mismatch/skip > halt > timeout.
- count == 0: run passes on the first HALT.
- CFG_WE and START in RUN are ignored. RST at any point returns to IDLE with all outputs zero.

## Timing
- Inputs are sampled on the rising edge. Every output is registered, so a verdict appears one cycle after the edge that sampled the deciding inputs.
- Reset values: BUSY=0, DONE=0, PASS=0, FAIL_CODE=0, FAIL_IDX=0, FAIL_VALUE=0, CYCLE=0, ptr=0, count=0.
- START to BUSY: 1 cycle. CYCLE reads 1 after the first RUN cycle.
- A table write is visible to a START issued in the following cycle. If CFG_WE and START occur in the same cycle, the run uses the old entry.
- NUM_INST may hold one value for many cycles. Each entry is checked once because ptr advances past it.
- PASS and FAIL hold until START or RST.

## Configuration
- RC_TIMEOUT_EN defined: in RUN, when CYCLE reaches TIMEOUT with no other event that cycle, go to FAIL with FAIL_CODE=4 and FAIL_IDX=ptr.
- RC_TIMEOUT_EN undefined: no watchdog, code 4 is never produced, and TIMEOUT is unused.

## Structure
- Shared package/header rc_pkg holds the state encoding (IDLE=0, RUN=1, PASS=2, FAIL=3) and the FAIL_CODE constants 0–4.
- Sub-module rc_table: NUM_TEST x 64-bit register file with a synchronous write port and a combinational read at ptr.
- Top level holds the FSM, ptr, count and CYCLE.

## Test plan
- Load entries {4:0x0eec, 6:0x0000, 8:0x0001}, count=3, START. Drive matching values at NUM_INST 4, 6, 8, then HALT at NUM_INST 10 -> PASS=1, DONE=1, FAIL_CODE=0.
- Same table, OUTPUT_PORT=0x0eed at NUM_INST=4 -> FAIL_CODE=1, FAIL_IDX=0, FAIL_VALUE=0x0eed, one cycle later.
- Same table, NUM_INST jumps 4 -> 7 -> FAIL_CODE=2, FAIL_IDX=1.
- Same table, HALT while NUM_INST=6 with entries 0–1 passed -> FAIL_CODE=3, FAIL_IDX=2. Then issue START -> BUSY=1, CYCLE=0, FAIL_CODE=0.
- count=0, START, HALT on the 5th RUN cycle -> PASS=1, CYCLE=5. RST in mid-run -> all outputs 0, IDLE.
- With RC_TIMEOUT_EN and TIMEOUT=20, never HALT -> FAIL_CODE=4 with CYCLE=20. Without the macro, the run stays BUSY past 20 cycles.
